// File: rtl/color_pkg.sv
// Shared constants, types and helpers for the colour/pixel FIFO blocks.
package color_pkg;

    localparam int PIXEL_W       = 32;
    localparam int DEFAULT_DEPTH = 8;
    localparam int DEFAULT_AEMPTY = 1;

    typedef struct packed {
        logic empty;
        logic full;
    } fifo_flags_t;

    // Smallest r with 2**r >= n; usable in parameter defaults.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int default_afull(input int depth);
        return depth - 2;
    endfunction

endpackage

// File: rtl/color_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module color_fifo_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 3
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/color_fifo.sv
// First-word-fall-through pixel FIFO with rts/rtr handshakes, occupancy and watermarks.
// Optional high-water-mark output enabled by defining COLOR_FIFO_HWM_EN.
module color_fifo
    import color_pkg::*;
#(
    parameter int DATA_WIDTH    = PIXEL_W,
    parameter int DEPTH         = DEFAULT_DEPTH,
    parameter int ADDR_W        = clog2(DEPTH),
    parameter int AFULL_THRESH  = default_afull(DEPTH),
    parameter int AEMPTY_THRESH = DEFAULT_AEMPTY
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_rts,
    output logic                  in_rtr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_rts,
    input  logic                  out_rtr,
    output logic [ADDR_W:0]       count,
    output logic                  almost_full,
    output logic                  almost_empty
`ifdef COLOR_FIFO_HWM_EN
    ,
    output logic [ADDR_W:0]       hwm
`endif
);

    if (DEPTH < 2 || DEPTH != (1 << ADDR_W)) begin : g_bad_depth
        $error("color_fifo: DEPTH must be a power of two >= 2 equal to 2**ADDR_W");
    end
    if (AFULL_THRESH < 0 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("color_fifo: AFULL_THRESH outside 0..DEPTH");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH) begin : g_bad_aempty
        $error("color_fifo: AEMPTY_THRESH outside 0..DEPTH");
    end

    localparam logic [ADDR_W:0] AFullThr  = AFULL_THRESH[ADDR_W:0];
    localparam logic [ADDR_W:0] AEmptyThr = AEMPTY_THRESH[ADDR_W:0];

    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0] count_q, count_d;
    fifo_flags_t     flags;
    logic            in_xfc, out_xfc;

    // Wrap bit distinguishes full from empty when the low bits match.
    always_comb begin
        flags.empty = (wr_ptr_q == rd_ptr_q);
        flags.full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                      (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    end

    assign in_rtr  = !flags.full && !flush;
    assign out_rts = !flags.empty && !flush;
    assign in_xfc  = in_rts && in_rtr;
    assign out_xfc = out_rts && out_rtr;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (in_xfc) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (out_xfc) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({in_xfc, out_xfc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    color_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (in_xfc),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (in_data),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (out_data)
    );

    assign count        = count_q;
    assign almost_full  = (count_q >= AFullThr);
    assign almost_empty = (count_q <= AEmptyThr);

`ifdef COLOR_FIFO_HWM_EN
    // Peak occupancy; deliberately untouched by flush.
    logic [ADDR_W:0] hwm_q, hwm_d;

    always_comb begin
        hwm_d = hwm_q;
        if (count_q > hwm_q) begin
            hwm_d = count_q;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign hwm = hwm_q;
`endif

endmodule
